// File: rtl/adder_seq.sv
// Chunk-serial adder/subtractor: WIDTH-bit operands summed CHUNK bits per clock.
// Latency: N = WIDTH/CHUNK cycles from the accepting edge to out_valid.
// Backpressure: one operation in flight; in_ready drops until the result is taken via out_ready.
module adder_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   S,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;       // effective B: already inverted for subtract
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   r_s;
  logic             r_ovf;

  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK:0]   w_sum;
  logic             w_last;

  // Final chunk is the one whose edge moves us into DONE.
  always_comb begin
    w_last = (r_cnt == CW'(N - 1));
  end

  // Select the current operand chunks and add them with the carried-in bit.
  always_comb begin
    w_a_chunk = '0;
    w_b_chunk = '0;
    for (int i = 0; i < N; i++) begin
      if (r_cnt == CW'(i)) begin
        w_a_chunk = r_a[i*CHUNK +: CHUNK];
        w_b_chunk = r_b[i*CHUNK +: CHUNK];
      end
    end
    w_sum = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
  end

  // Next-state logic for IDLE -> RUN -> DONE -> IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = RUN;
      RUN:     if (w_last)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register; reset wins over any handshake on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath: latch operands on accept, then fill S one chunk per RUN edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_s     <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= A;
            r_b     <= sub ? ~B : B;
            r_carry <= sub ? 1'b1 : cin;
            r_cnt   <= '0;
            r_s     <= '0;
            r_ovf   <= 1'b0;
          end
        end
        RUN: begin
          for (int i = 0; i < N; i++) begin
            if (r_cnt == CW'(i)) begin
              r_s[i*CHUNK +: CHUNK] <= w_sum[CHUNK-1:0];
            end
          end
          r_carry <= w_sum[CHUNK];
          if (w_last) begin
            // Top chunk holds the sign bit, so overflow is judged from this sum.
            r_s[WIDTH] <= w_sum[CHUNK];
            r_ovf      <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                          (w_sum[CHUNK-1] != r_a[WIDTH-1]);
            r_cnt      <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign S         = r_s;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_adder_seq.sv
// Self-checking bench for adder_seq (WIDTH=16, CHUNK=4).
// Directed vectors plus randomized operations against an integer-arithmetic model.
// Covers backpressure, ignored inputs while busy, and reset during an operation.
module tb_adder_seq;

  localparam int W  = 16;
  localparam int C  = 4;
  localparam int NC = W / C;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic          cin = 1'b0;
  logic          sub = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W:0]    S;
  logic          ovf;

  int n_checks = 0;
  int n_errors = 0;

  adder_seq #(.WIDTH(W), .CHUNK(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the operation as the user sees it.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic ci, input logic sb,
                                output logic [W:0] s, output logic o);
    int ua, ub, sa, sbv, r;
    ua  = int'(a);
    ub  = int'(b);
    sa  = a[W-1] ? ua - 65536 : ua;
    sbv = b[W-1] ? ub - 65536 : ub;
    if (!sb) begin
      s = 17'(ua + ub + (ci ? 1 : 0));
      r = sa + sbv + (ci ? 1 : 0);
    end else begin
      s[W-1:0] = 16'(ua - ub);
      s[W]     = (ua >= ub);
      r = sa - sbv;
    end
    o = (r > 32767) || (r < -32768);
  endfunction

  // Issue one operation, wait for the result, then consume it after 'hold' stall cycles.
  // lat = -1 means the handshake never completed.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic sb, input int hold,
                        output logic [W:0] s, output logic o, output int lat);
    int guard;
    guard = 0;
    lat = -1;
    s = '0;
    o = 1'b0;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) return;
    A = a; B = b; cin = ci; sub = sb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = W'($urandom); B = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    s = S;
    o = ovf;
    repeat (hold) @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (S !== 17'h0) begin n_errors++; $display("FAIL reset_S got=%h exp=00000", S); end
    n_checks++; if (ovf !== 1'b0) begin n_errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         sb;
    logic [W:0]   s;
    logic         o;
  } vec_t;

  task automatic test_directed();
    vec_t vt[9];
    logic [W:0] s;
    logic o;
    int lat;
    vt[0] = '{16'h0002, 16'h0001, 1'b0, 1'b0, 17'h00003, 1'b0};
    vt[1] = '{16'h0003, 16'h0004, 1'b0, 1'b0, 17'h00007, 1'b0};
    vt[2] = '{16'h0007, 16'h0009, 1'b0, 1'b0, 17'h00010, 1'b0};
    vt[3] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000, 1'b0};
    vt[4] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 17'h10000, 1'b0};
    vt[5] = '{16'h0003, 16'h0004, 1'b1, 1'b1, 17'h0FFFF, 1'b0};
    vt[6] = '{16'h0004, 16'h0003, 1'b0, 1'b1, 17'h10001, 1'b0};
    vt[7] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 17'h08000, 1'b1};
    vt[8] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 17'h17FFF, 1'b1};
    for (int i = 0; i < 9; i++) begin
      run_op(vt[i].a, vt[i].b, vt[i].ci, vt[i].sb, 0, s, o, lat);
      n_checks++; if (lat !== NC) begin n_errors++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, NC); end
      n_checks++; if (s !== vt[i].s) begin n_errors++; $display("FAIL dir%0d_S got=%h exp=%h", i, s, vt[i].s); end
      n_checks++; if (o !== vt[i].o) begin n_errors++; $display("FAIL dir%0d_ovf got=%b exp=%b", i, o, vt[i].o); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic ci, sb, eo, o;
    logic [W:0] es, s;
    int lat;
    for (int i = 0; i < 40; i++) begin
      a  = W'($urandom);
      b  = W'($urandom);
      ci = 1'($urandom);
      sb = 1'($urandom);
      if (i % 5 == 0) a = {1'b0, {(W-1){1'b1}}};   // push toward the signed boundary
      model(a, b, ci, sb, es, eo);
      run_op(a, b, ci, sb, $urandom_range(0, 3), s, o, lat);
      n_checks++; if (lat !== NC) begin n_errors++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, NC); end
      n_checks++; if (s !== es) begin n_errors++; $display("FAIL rnd%0d_S a=%h b=%h ci=%b sub=%b got=%h exp=%h", i, a, b, ci, sb, s, es); end
      n_checks++; if (o !== eo) begin n_errors++; $display("FAIL rnd%0d_ovf a=%h b=%h sub=%b got=%b exp=%b", i, a, b, sb, o, eo); end
    end
  endtask

  task automatic test_backpressure();
    logic [W:0] es;
    logic eo;
    int guard;
    model(16'h1234, 16'h0F0F, 1'b1, 1'b0, es, eo);
    A = 16'h1234; B = 16'h0F0F; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    guard = 0;
    while (out_valid !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    n_checks++; if (guard >= 50) begin n_errors++; $display("FAIL bp_done_timeout got=timeout exp=out_valid"); end
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'($urandom); A = W'($urandom); B = W'($urandom); sub = 1'($urandom);
      @(posedge clk); #1;
      n_checks++; if (S !== es) begin n_errors++; $display("FAIL bp_hold%0d_S got=%h exp=%h", k, S, es); end
      n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_hold%0d_in_ready got=%b exp=0", k, in_ready); end
      n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL bp_hold%0d_out_valid got=%b exp=1", k, out_valid); end
    end
    // Consume with in_valid still high: that offer must not be taken.
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL bp_release_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (S !== es || ovf !== eo) begin n_errors++; $display("FAIL bp_release_keep got=%h/%b exp=%h/%b", S, ovf, es, eo); end
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL bp_no_accept in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [W:0] s, es;
    logic o, eo;
    int lat, t0, t1;
    t0 = 0; t1 = 0;
    for (int i = 0; i < 3; i++) begin
      model(16'(i * 16'h1111), 16'h0FF1, 1'b0, 1'b0, es, eo);
      t1 = int'($time);
      run_op(16'(i * 16'h1111), 16'h0FF1, 1'b0, 1'b0, 0, s, o, lat);
      n_checks++; if (s !== es) begin n_errors++; $display("FAIL b2b%0d_S got=%h exp=%h", i, s, es); end
      if (i > 0) begin
        // Each run_op starts right after the previous consume edge.
        n_checks++; if ((t1 - t0) / 10 !== NC + 2) begin n_errors++; $display("FAIL b2b%0d_interval got=%0d exp=%0d", i, (t1 - t0) / 10, NC + 2); end
      end
      t0 = t1;
    end
  endtask

  task automatic test_reset_mid();
    logic [W:0] s;
    logic o;
    int lat;
    bit seen;
    A = 16'h1234; B = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;        // first RUN edge done
    rst = 1'b1;
    @(posedge clk); #1;        // second RUN edge sees reset
    rst = 1'b0;
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
    n_checks++; if (S !== 17'h0) begin n_errors++; $display("FAIL rstmid_S got=%h exp=00000", S); end
    n_checks++; if (ovf !== 1'b0) begin n_errors++; $display("FAIL rstmid_ovf got=%b exp=0", ovf); end
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++; if (seen) begin n_errors++; $display("FAIL rstmid_out_valid got=asserted exp=never"); end
    run_op(16'h0002, 16'h0001, 1'b0, 1'b0, 0, s, o, lat);
    n_checks++; if (s !== 17'h00003) begin n_errors++; $display("FAIL rstmid_next_S got=%h exp=00003", s); end
    n_checks++; if (lat !== NC) begin n_errors++; $display("FAIL rstmid_next_latency got=%0d exp=%0d", lat, NC); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/adder_seq.md
ADDER_SEQ -- requirements
Module: adder_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits (>=2).
REQ-002 SHALL have parameter CHUNK, default 4, bits added per clock cycle; WIDTH is an integer multiple of CHUNK, CHUNK>=1; N = WIDTH/CHUNK.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operands and mode present.
REQ-006 SHALL have port in_ready  output  1  block can accept an operation.
REQ-007 SHALL have port A  input  WIDTH  operand A.
REQ-008 SHALL have port B  input  WIDTH  operand B.
REQ-009 SHALL have port cin  input  1  carry-in; used for add only.
REQ-010 SHALL have port sub  input  1  0 = add, 1 = subtract.
REQ-011 SHALL have port out_valid  output  1  result held and valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-013 SHALL have port S  output  WIDTH+1  result; S[WIDTH] is the carry-out.
REQ-014 SHALL have port ovf  output  1  two's-complement signed overflow of S[WIDTH-1:0].

Function
REQ-015 SHALL implement an FSM with states IDLE, RUN and DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-016 SHALL, in IDLE on an edge with in_valid=1, latch A, the effective B (B if sub=0, ~B if sub=1) and the initial carry (cin if sub=0, 1 if sub=1), clear the chunk counter and S, and enter RUN.
REQ-017 SHALL ignore cin when sub=1 and ignore all input signals while not in IDLE.
REQ-018 SHALL, in RUN, add chunk i (bits i*CHUNK+CHUNK-1 down to i*CHUNK) plus the registered carry on edge i (i = 0..N-1 counted from the first RUN edge), write the sum bits into S, and register the chunk carry-out.
REQ-019 SHALL, on the edge that processes chunk N-1, write the final carry into S[WIDTH], compute ovf = (A[W-1]==Beff[W-1]) && (S[W-1]!=A[W-1]), and enter DONE.
REQ-020 SHALL give a latency of exactly N cycles from the accepting edge to the first cycle with out_valid=1 (CHUNK==WIDTH gives 1 cycle).
REQ-021 SHALL hold S and ovf stable in DONE for as long as out_ready=0.
REQ-022 SHALL, in DONE on an edge with out_ready=1, return to IDLE; S and ovf keep their values until the next accept.
REQ-023 SHALL not accept a new operation in the same cycle a result is consumed; minimum issue interval is N+2 cycles.
REQ-024 SHALL produce S = A + B + cin modulo 2^(WIDTH+1) for add, and S[WIDTH-1:0] = A - B modulo 2^WIDTH with S[WIDTH] = 1 meaning no borrow for subtract.
REQ-025 SHALL wrap the chunk counter only through the transition to DONE; the counter never exceeds N-1.

Reset
REQ-026 SHALL, on any edge with rst=1, enter IDLE and clear S, ovf, the carry register and the chunk counter, regardless of state; in_ready=1 and out_valid=0 on the following cycle.
REQ-027 SHALL give rst priority over in_valid and out_ready on the same edge; an operation in RUN or DONE that is aborted by reset is discarded and produces no out_valid.

Verification (WIDTH=16, CHUNK=4, N=4)
REQ-028 SHALL test add A=2, B=1, cin=0 -> out_valid 4 cycles after accept, S=0x00003, ovf=0; then A=3, B=4 -> S=0x00007; then A=7, B=9 -> S=0x00010.
REQ-029 SHALL test full-width carry A=0xFFFF, B=0x0001, cin=0 -> S=0x10000, ovf=0; and A=0xFFFF, B=0x0000, cin=1 -> S=0x10000.
REQ-030 SHALL test subtract A=3, B=4, sub=1, cin=1 -> S=0x0FFFF (S[16]=0, borrow), ovf=0; and A=4, B=3, sub=1 -> S=0x10001.
REQ-031 SHALL test signed overflow A=0x7FFF, B=0x0001, add -> S=0x08000, ovf=1; and A=0x8000, B=0x0001, sub=1 -> S=0x17FFF, ovf=1.
REQ-032 SHALL test backpressure: hold out_ready=0 for 5 cycles in DONE -> S constant, in_ready=0, new in_valid pulses ignored; then out_ready=1 -> IDLE next cycle.
REQ-033 SHALL test reset mid-operation: rst=1 on the 2nd RUN edge -> IDLE, S=0, ovf=0, out_valid never asserts; the next operation A=2, B=1 -> S=0x00003.
